// File: rtl/ysyx_22040931_if_stage_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_if_stage_pkg
// Shared constants and types for the instruction-fetch stage.
//   PC_BUS / INST_BUS : default PC and instruction widths
//   RESET_PC_DEF      : architectural PC after reset
//   NOP_INST          : instruction shown on instr_o while nothing was fetched
//   fetch_state_e     : fetch FSM states (2-bit encoding)
// ----------------------------------------------------------------------------
package ysyx_22040931_if_stage_pkg;

    localparam int          PC_BUS       = 64;
    localparam int          INST_BUS     = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ysyx_22040931_if_hold_buf.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_if_hold_buf
// One-entry {pc, instr} buffer that parks a fetched instruction while the
// decode-facing output register is still occupied.
//   clock, reset        : clock and synchronous active-high reset
//   load, load_pc/instr : capture a new entry
//   clear               : drop the entry (wins over load)
//   valid, pc, instr    : buffered entry
// ----------------------------------------------------------------------------
module ysyx_22040931_if_hold_buf #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   load_pc,
    input  logic [INST_W-1:0] load_instr,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] instr
);

    // Clear takes priority so a redirect can never leave a wrong-path entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/ysyx_22040931_if_stage.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_if_stage
// Instruction-fetch stage: owns the architectural PC, issues one imem fetch at
// a time and presents {pc, instr} to decode through a valid/ready register.
// A qualified redirect from decode (mux_pc_i while valid_o) retargets the PC
// and squashes any wrong-path fetch, including one already in flight.
//   clock, reset                  : clock, synchronous active-high reset
//   imem_req_valid/ready/addr     : fetch request channel
//   imem_rsp_valid/data           : fetch response (one per accepted request)
//   mux_pc_i, branch_i            : redirect request and target from decode
//   valid_o, ready_i, pc_o, instr_o : decode-facing output register
// ----------------------------------------------------------------------------
module ysyx_22040931_if_stage
    import ysyx_22040931_if_stage_pkg::*;
#(
    parameter int              PC_W     = PC_BUS,
    parameter int              INST_W   = INST_BUS,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              mux_pc_i,
    input  logic [PC_W-1:0]   branch_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] instr_o
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    fetch_state_e      state;
    logic [PC_W-1:0]   pc_r;
    logic              kill_r;

    logic              redirect;
    logic              slot_free;
    logic              hold_load;
    logic              hold_clear;
    logic              hold_valid;
    logic [PC_W-1:0]   hold_pc;
    logic [INST_W-1:0] hold_instr;

    // The request channel depends only on the state register; pc_r is always
    // word aligned because both the reset PC and redirect targets are.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc_r;

    assign redirect   = mux_pc_i & valid_o;
    assign slot_free  = ~valid_o | ready_i;
    assign hold_load  = (state == S_WAIT) & imem_rsp_valid & ~kill_r
                      & ~slot_free & ~redirect;
    assign hold_clear = redirect | ((state == S_HOLD) & ready_i);

    ysyx_22040931_if_hold_buf #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_hold_buf (
        .clock      (clock),
        .reset      (reset),
        .load       (hold_load),
        .clear      (hold_clear),
        .load_pc    (pc_r),
        .load_instr (imem_rsp_data),
        .valid      (hold_valid),
        .pc         (hold_pc),
        .instr      (hold_instr)
    );

    // Fetch FSM, PC, kill flag and output register. A redirect overrides
    // everything else in its cycle: the presented instruction is consumed, a
    // response arriving now is dropped, and a request that is still
    // outstanding (or handshaking right now) is marked for killing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_REQ;
            pc_r    <= RESET_PC;
            kill_r  <= 1'b0;
            valid_o <= 1'b0;
            pc_o    <= '0;
            instr_o <= INST_W'(NOP_INST);
        end else if (redirect) begin
            pc_r    <= {branch_i[PC_W-1:2], 2'b00};
            valid_o <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state  <= S_WAIT;
                        kill_r <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state  <= S_REQ;
                        kill_r <= 1'b0;
                    end else begin
                        kill_r <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            // A consumed slot empties unless a new load below refills it.
            if (ready_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill_r) begin
                            kill_r <= 1'b0;
                            state  <= S_REQ;
                        end else if (slot_free) begin
                            valid_o <= 1'b1;
                            pc_o    <= pc_r;
                            instr_o <= imem_rsp_data;
                            pc_r    <= pc_r + PC_STEP;
                            state   <= S_REQ;
                        end else begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (ready_i && hold_valid) begin
                        valid_o <= 1'b1;
                        pc_o    <= hold_pc;
                        instr_o <= hold_instr;
                        pc_r    <= pc_r + PC_STEP;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule
